uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter between N_REQ byte requesters (e.g. RX-echo FIFO, status reporter).

---
 rtl/uart_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: arbiter FSM states,
// UART data width, and the width helper for requester indices.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } arb_state_e;

   // Width of a requester index; at least one bit even for a single requester
   function automatic int id_width(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter: picks the first asserted request
// at or after ptr (wrapping), returning it one-hot and as an index.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IDW   = id_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDW-1:0]   grant_idx,
   output logic             grant_any
);

   logic [2*N_REQ-1:0] dbl_s;
   logic               take_s;

   // Rotate requests so ptr lands at bit 0, then take the lowest set bit
   always_comb begin
      dbl_s     = {req, req} >> ptr;
      grant_idx = '0;
      grant_any = 1'b0;
      take_s    = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         take_s    = dbl_s[i] & ~grant_any;
         grant_idx = take_s ? IDW'((int'(ptr) + i) % N_REQ) : grant_idx;
         grant_any = grant_any | dbl_s[i];
      end
      grant = grant_any ? (N_REQ'(1'b1) << grant_idx) : '0;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources.
// One byte in flight at a time: accept in IDLE, pulse tx_start, wait for the
// transmitter to go busy (bounded by BUSY_WAIT cycles), then wait for done.
// Optional build macro UART_ARB_PKT_LOCK_EN keeps the grant on one requester
// until it sends a byte flagged req_last.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ     = 2,
   parameter int BUSY_WAIT = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_REQ-1:0]               req_valid,
   input  logic [UART_DATA_W*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]               req_last,
   output logic [N_REQ-1:0]               req_ready,
   output logic                           tx_start,
   output logic [UART_DATA_W-1:0]         tx_din,
   input  logic                           tx_busy,
   input  logic                           tx_done,
   output logic [id_width(N_REQ)-1:0]     grant_id,
   output logic                           arb_busy,
   output logic                           launch_err
);

   localparam int                IDW       = id_width(N_REQ);
   localparam int                CNT_W     = $clog2(BUSY_WAIT + 1);
   localparam logic [IDW-1:0]    LAST_IDX  = IDW'(N_REQ - 1);
   // Busy is sampled in WAIT_BUSY with cnt_r = 1 .. BUSY_WAIT-1, so an
   // abandoned launch raises launch_err exactly BUSY_WAIT cycles after tx_start.
   localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(BUSY_WAIT - 1);

   arb_state_e               state_r;
   arb_state_e               state_nx_s;
   logic [IDW-1:0]           ptr_r;
   logic [CNT_W-1:0]         cnt_r;
   logic                     tx_start_r;
   logic [UART_DATA_W-1:0]   tx_din_r;
   logic [IDW-1:0]           grant_id_r;
   logic                     arb_busy_r;
   logic                     launch_err_r;
   logic [N_REQ-1:0]         arb_req_s;
   logic [N_REQ-1:0]         arb_grant_s;
   logic [IDW-1:0]           arb_idx_s;
   logic                     arb_any_s;
   logic                     accept_s;
   logic                     abandon_s;
   logic [UART_DATA_W-1:0]   sel_byte_s;

   // Successor of a requester index, wrapping N_REQ-1 back to 0
   function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
      if (idx == LAST_IDX) begin
         return '0;
      end else begin
         return idx + IDW'(1'b1);
      end
   endfunction

`ifdef UART_ARB_PKT_LOCK_EN
   logic                     lock_r;
   logic [IDW-1:0]           lock_id_r;
   logic                     sel_last_s;

   // While a packet is open only its owner may compete
   always_comb begin
      if (lock_r) begin
         arb_req_s = req_valid & (N_REQ'(1'b1) << lock_id_r);
      end else begin
         arb_req_s = req_valid;
      end
   end

   // End-of-packet flag of the winning requester
   always_comb begin
      sel_last_s = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_last_s = sel_last_s | (req_last[i] & arb_grant_s[i]);
      end
   end

   // Pointer moves only when a packet closes; abandoned launches close it too
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r     <= '0;
         lock_r    <= 1'b0;
         lock_id_r <= '0;
      end else if (accept_s) begin
         if (sel_last_s) begin
            ptr_r  <= next_idx(arb_idx_s);
            lock_r <= 1'b0;
         end else begin
            lock_r    <= 1'b1;
            lock_id_r <= arb_idx_s;
         end
      end else if (abandon_s) begin
         ptr_r  <= next_idx(grant_id_r);
         lock_r <= 1'b0;
      end
   end
`else
   logic unused_last_s;
   assign unused_last_s = ^req_last;
   assign arb_req_s     = req_valid;

   // Pointer moves past every accepted requester
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= '0;
      end else if (accept_s) begin
         ptr_r <= next_idx(arb_idx_s);
      end
   end
`endif

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_rr (
      .req       (arb_req_s),
      .ptr       (ptr_r),
      .grant     (arb_grant_s),
      .grant_idx (arb_idx_s),
      .grant_any (arb_any_s)
   );

   // Pick the winner's byte out of the packed data bus
   always_comb begin
      sel_byte_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_byte_s = sel_byte_s
                    | (req_data[UART_DATA_W*i +: UART_DATA_W] & {UART_DATA_W{arb_grant_s[i]}});
      end
   end

   // Next-state logic; accept and abandon are single-cycle decisions
   always_comb begin
      state_nx_s = state_r;
      accept_s   = 1'b0;
      abandon_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (arb_any_s && !tx_busy) begin
               accept_s   = 1'b1;
               state_nx_s = ST_LAUNCH;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            state_nx_s = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_nx_s = ST_WAIT_DONE;
            end else if (cnt_r >= CNT_LIMIT) begin
               abandon_s  = 1'b1;
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_DONE: begin
            // A busy drop without a done pulse also ends the byte
            if (tx_done || !tx_busy) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_WAIT_DONE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         cnt_r        <= '0;
         tx_start_r   <= 1'b0;
         tx_din_r     <= 8'h00;
         grant_id_r   <= '0;
         arb_busy_r   <= 1'b0;
         launch_err_r <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         cnt_r        <= (state_r == ST_WAIT_BUSY) ? cnt_r + CNT_W'(1'b1) : CNT_W'(1'b1);
         tx_start_r   <= (state_nx_s == ST_LAUNCH);
         arb_busy_r   <= (state_nx_s != ST_IDLE);
         launch_err_r <= abandon_s;
         if (accept_s) begin
            tx_din_r   <= sel_byte_s;
            grant_id_r <= arb_idx_s;
         end
      end
   end

   assign req_ready  = (accept_s && !rst) ? arb_grant_s : '0;
   assign tx_start   = tx_start_r;
   assign tx_din     = tx_din_r;
   assign grant_id   = grant_id_r;
   assign arb_busy   = arb_busy_r;
   assign launch_err = launch_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N_REQ=4, BUSY_WAIT=4).
// A timing-level reference model (cycles since accept, busy seen or not)
// predicts every output each cycle; directed sequences pin literal values.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int BW = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [8*N-1:0]   req_data = '0;
   logic [N-1:0]     req_last = '0;
   logic [N-1:0]     req_ready;
   logic             tx_start;
   logic [7:0]       tx_din;
   logic             tx_busy = 1'b0;
   logic             tx_done = 1'b0;
   logic [1:0]       grant_id;
   logic             arb_busy;
   logic             launch_err;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N), .BUSY_WAIT(BW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .tx_start   (tx_start),
      .tx_din     (tx_din),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .grant_id   (grant_id),
      .arb_busy   (arb_busy),
      .launch_err (launch_err)
   );

   int n_vec = 0;
   int n_err = 0;

   // stimulus requested for the next cycle
   logic           st_rst = 1'b1;
   logic [N-1:0]   st_valid = '0;
   logic [N-1:0]   st_last = '0;
   logic [8*N-1:0] st_data = '0;

   // reference model
   bit         m_inflight = 0;
   int         m_age = 0;
   bit         m_seen = 0;
   bit         m_err = 0;
   int         m_ptr = 0;
   logic [7:0] m_din = 8'h00;
   int         m_gid = 0;
   bit         m_lock = 0;
   int         m_lock_id = 0;

   // values seen in the previous cycle
   logic           s_rst = 1'b1;
   logic [8*N-1:0] s_data = '0;
   logic [N-1:0]   s_last = '0;
   logic           s_busy = 1'b0;
   logic           s_done = 1'b0;
   logic           s_start = 1'b0;
   int             s_win = -1;

   // transmitter model: x_force 0 = well-behaved, 1 = never busy, -1 = random
   bit x_active = 0;
   int x_cnt = 0;
   int x_delay = 0;
   int x_len = 0;
   bit x_nodone = 0;
   int x_force = 0;

   int         acc_q[$];
   logic [7:0] din_q[$];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int winner(input logic [N-1:0] v);
      logic [N-1:0] elig;
      elig = v;
`ifdef UART_ARB_PKT_LOCK_EN
      if (m_lock) elig = v & (N'(1) << m_lock_id);
`endif
      for (int k = 0; k < N; k++) begin
         if (elig[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   // advance the model across one clock edge
   task automatic model_step();
      m_err = 0;
      if (s_rst) begin
         m_inflight = 0; m_ptr = 0; m_din = 8'h00; m_gid = 0; m_lock = 0;
      end else if (!m_inflight) begin
         if (s_win >= 0) begin
            m_inflight = 1; m_age = 1; m_seen = 0;
            m_din = s_data[8*s_win +: 8];
            m_gid = s_win;
`ifdef UART_ARB_PKT_LOCK_EN
            if (s_last[s_win]) begin m_lock = 0; m_ptr = (s_win + 1) % N; end
            else begin m_lock = 1; m_lock_id = s_win; end
`else
            m_ptr = (s_win + 1) % N;
`endif
         end
      end else if (m_age == 1) begin
         m_age = 2;
      end else if (!m_seen) begin
         if (s_busy) m_seen = 1;
         else if (m_age >= BW) begin
            m_inflight = 0; m_err = 1;
`ifdef UART_ARB_PKT_LOCK_EN
            m_lock = 0; m_ptr = (m_gid + 1) % N;
`endif
         end else m_age++;
      end else if (s_done || !s_busy) begin
         m_inflight = 0;
      end
   endtask

   // transmitter reacting to the tx_start it saw last cycle
   task automatic xmit_step();
      int r;
      if (s_rst) x_active = 0;
      else if (s_start) begin
         x_active = 1; x_cnt = 0; x_nodone = 0; x_delay = 1; x_len = 6;
         r = (x_force < 0) ? $urandom_range(0, 9) : ((x_force == 1) ? 0 : 9);
         if (x_force < 0) x_len = $urandom_range(1, 12);
         if (r == 0) begin x_delay = 0; x_len = 8; end
         else if (r == 1) x_delay = $urandom_range(2, 6);
         else if (r == 2) x_nodone = 1;
      end
      tx_busy = 1'b0;
      tx_done = 1'b0;
      if (x_active) begin
         x_cnt++;
         tx_busy = (x_delay > 0) && (x_cnt >= x_delay) && (x_cnt < x_delay + x_len);
         tx_done = (x_delay > 0) && !x_nodone && (x_cnt == x_delay + x_len - 1);
         if (x_cnt >= x_delay + x_len) x_active = 0;
      end else if (x_force < 0) begin
         tx_done = ($urandom_range(0, 19) == 0);
      end
   endtask

   // compare every DUT output with the model for the current cycle
   task automatic check_cycle();
      int w;
      logic [N-1:0] exp_ready;
      w = (!m_inflight && !rst && !tx_busy) ? winner(req_valid) : -1;
      exp_ready = (w >= 0) ? (N'(1) << w) : '0;
      chk("req_ready", req_ready, exp_ready);
      chk("tx_start", tx_start, m_inflight && m_age == 1);
      chk("arb_busy", arb_busy, m_inflight);
      chk("launch_err", launch_err, m_err);
      chk("tx_din", tx_din, m_din);
      chk("grant_id", grant_id, m_gid);
      for (int k = 0; k < N; k++) if (req_ready[k] && req_valid[k]) acc_q.push_back(k);
      if (tx_start) din_q.push_back(tx_din);
      s_rst = rst; s_data = req_data; s_last = req_last;
      s_busy = tx_busy; s_done = tx_done; s_start = tx_start; s_win = w;
   endtask

   task automatic cycle();
      @(negedge clk);
      model_step();
      xmit_step();
      rst = st_rst; req_valid = st_valid; req_data = st_data; req_last = st_last;
      #1;
      check_cycle();
   endtask

   task automatic drain();
      st_valid = '0;
      for (int k = 0; k < 30; k++) cycle();
   endtask

   task automatic do_reset();
      st_rst = 1'b1; cycle(); st_rst = 1'b0; cycle();
   endtask

   // offer one byte, wait for acceptance, then step into the launch cycle
   task automatic send(input logic [N-1:0] v);
      int n0;
      bit ok;
      n0 = acc_q.size(); ok = 0; st_valid = v;
      for (int k = 0; k < 40 && !ok; k++) begin
         cycle();
         ok = (acc_q.size() > n0);
      end
      st_valid = '0;
      chk("send_accepted", ok, 1'b1);
      cycle();
   endtask

   task automatic collect(input logic [N-1:0] v, input int n);
      st_valid = v;
      for (int k = 0; k < 300 && acc_q.size() < n; k++) cycle();
      st_valid = '0;
      chk("collect_count", acc_q.size(), n);
   endtask

   initial begin
      int k;
      int n0;
      int exp2[4] = '{0, 1, 0, 1};
      int exp6[4];
      logic [7:0] expd[4] = '{8'hAA, 8'h55, 8'hAA, 8'h55};
`ifdef UART_ARB_PKT_LOCK_EN
      exp6 = '{0, 0, 0, 1};
`else
      exp6 = '{0, 1, 0, 1};
`endif
      x_force = 0;
      do_reset(); cycle();
      chk("rst_tx_din", tx_din, 8'h00);
      chk("rst_arb_busy", arb_busy, 1'b0);

      // single byte
      st_data = '0; st_data[7:0] = 8'h41; st_valid = 4'b0001; cycle();
      chk("t1_ready", req_ready, 4'b0001);
      st_valid = '0; cycle();
      chk("t1_start", tx_start, 1'b1);
      chk("t1_din", tx_din, 8'h41);
      for (k = 1; k < 30; k++) begin cycle(); if (!arb_busy) break; end
      chk("t1_idle_after_done", k, 7);
      drain();

      // contention between two requesters from a fresh pointer
      do_reset(); acc_q.delete(); din_q.delete();
      st_data = {8'h00, 8'h00, 8'h55, 8'hAA};
      collect(4'b0011, 4); drain();
      for (int i = 0; i < 4; i++) chk($sformatf("t2_grant%0d", i), acc_q[i], exp2[i]);
      chk("t2_din_count", din_q.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t2_din%0d", i), din_q[i], expd[i]);

      // pointer at 3 with only requesters 3 and 0 active
      st_data = {8'h33, 8'h22, 8'h11, 8'h00};
      send(4'b0100); drain(); acc_q.delete();
      collect(4'b1001, 3); drain();
      chk("t3_grant0", acc_q[0], 3);
      chk("t3_grant1", acc_q[1], 0);
      chk("t3_grant2", acc_q[2], 3);

      // transmitter never goes busy
      x_force = 1; send(4'b0001);
      for (k = 1; k < 20; k++) begin cycle(); if (launch_err) break; end
      chk("t4_err_delay", k, BW);
      chk("t4_idle_at_err", arb_busy, 1'b0);
      cycle(); chk("t4_err_pulse", launch_err, 1'b0);
      x_force = 0; acc_q.delete();
      send(4'b0010); drain();
      chk("t4_next_grant", acc_q[0], 1);

      // reset in the middle of a byte
      send(4'b0100); cycle(); cycle(); cycle();
      chk("t5_busy_before", arb_busy, 1'b1);
      st_rst = 1'b1; cycle(); st_rst = 1'b0; cycle();
      chk("t5_tx_din", tx_din, 8'h00);
      chk("t5_grant_id", grant_id, 0);
      chk("t5_arb_busy", arb_busy, 1'b0);
      chk("t5_tx_start", tx_start, 1'b0);
      acc_q.delete(); send(4'b1010); drain();
      chk("t5_fresh_grant", acc_q[0], 1);

      // packet of three from requester 0 against a steady requester 1
      do_reset(); acc_q.delete();
      for (k = 0; k < 300 && acc_q.size() < 4; k++) begin
         n0 = 0;
         foreach (acc_q[i]) if (acc_q[i] == 0) n0++;
         st_valid = '0; st_last = '0;
         st_valid[1] = 1'b1; st_valid[0] = (n0 < 3);
         st_last[1] = 1'b1;  st_last[0] = (n0 == 2);
         cycle();
      end
      drain();
      chk("t6_count", acc_q.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t6_grant%0d", i), acc_q[i], exp6[i]);

      // randomized traffic
      x_force = -1;
      for (int r = 0; r < 3000; r++) begin
         if ($urandom_range(0, 3) == 0) st_valid = N'($urandom);
         st_data = $urandom;
         st_last = N'($urandom);
         st_rst = ($urandom_range(0, 299) == 0);
         cycle();
      end
      st_rst = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

endmodule
